// File: rtl/deflate_bit_packer.sv
// Packs variable-length Deflate codes (LSB first) into OUT_WIDTH-bit words with ready/valid and flush.
// Optional PACKER_BYTE_SWAP_EN: emit each word byte-reversed.
module deflate_bit_packer #(
  parameter int unsigned OUT_WIDTH    = 32,
  parameter int unsigned MAX_CODE_LEN = 28,
  parameter int unsigned LEN_WIDTH    = $clog2(MAX_CODE_LEN + 1),
  localparam int unsigned ACC_WIDTH   = OUT_WIDTH + MAX_CODE_LEN,
  localparam int unsigned BYTES_W     = $clog2(OUT_WIDTH / 8 + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    code_valid,
  input  logic [MAX_CODE_LEN-1:0] code_data,
  input  logic [LEN_WIDTH-1:0]    code_len,
  output logic                    code_ready,
  input  logic                    flush,
  output logic                    flush_done,
  output logic                    out_valid,
  output logic [OUT_WIDTH-1:0]    out_data,
  output logic                    out_last,
  output logic [BYTES_W-1:0]      out_bytes,
  input  logic                    out_ready
);

  localparam int unsigned CNT_W = $clog2(ACC_WIDTH + 1);

  typedef enum logic [1:0] {PACK, FLUSH, LAST} state_t;

  state_t                    state, state_nxt;
  logic [ACC_WIDTH-1:0]      acc, acc_eff, acc_nxt;
  logic [CNT_W-1:0]          cnt, cnt_eff, cnt_nxt;
  logic [MAX_CODE_LEN-1:0]   code_masked;
  logic [BYTES_W-1:0]        tail_bytes;
  logic                      slot_free, move_full, load_last, accept, last_taken;

  function automatic logic [OUT_WIDTH-1:0] fmt_word(input logic [OUT_WIDTH-1:0] w);
    logic [OUT_WIDTH-1:0] r;
    r = w;
`ifdef PACKER_BYTE_SWAP_EN
    for (int i = 0; i < int'(OUT_WIDTH / 8); i++) begin
      r[8*i +: 8] = w[OUT_WIDTH-8-8*i +: 8];
    end
`endif
    return r;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= PACK;
    else     state <= state_nxt;
  end

  // Next state; flush_done guards against re-entering FLUSH while the source still holds flush
  always_comb begin
    state_nxt = state;
    case (state)
      PACK:    if (flush && !flush_done) state_nxt = FLUSH;
      FLUSH:   if (load_last) state_nxt = LAST;
      LAST:    if (last_taken) state_nxt = PACK;
      default: state_nxt = PACK;
    endcase
  end

  // Control and accumulator update; an accept lands at the post-move bit position
  always_comb begin
    slot_free   = !out_valid || out_ready;
    move_full   = (cnt >= CNT_W'(OUT_WIDTH)) && slot_free;
    load_last   = (state == FLUSH) && (cnt < CNT_W'(OUT_WIDTH)) && slot_free;
    cnt_eff     = move_full ? cnt - CNT_W'(OUT_WIDTH) : cnt;
    acc_eff     = move_full ? (acc >> OUT_WIDTH) : acc;
    code_ready  = !rst && (state == PACK) && (cnt_eff < CNT_W'(OUT_WIDTH)) && !flush;
    accept      = code_valid && code_ready;
    last_taken  = (state == LAST) && out_valid && out_ready;
    code_masked = code_data & ~({MAX_CODE_LEN{1'b1}} << code_len);
    tail_bytes  = BYTES_W'((cnt + CNT_W'(7)) >> 3);
    acc_nxt     = acc_eff;
    cnt_nxt     = cnt_eff;
    if (load_last) begin
      acc_nxt = '0;
      cnt_nxt = '0;
    end else if (accept) begin
      acc_nxt = acc_eff | (ACC_WIDTH'(code_masked) << cnt_eff);
      cnt_nxt = cnt_eff + CNT_W'(code_len);
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_bytes  <= '0;
      flush_done <= 1'b0;
    end else begin
      acc        <= acc_nxt;
      cnt        <= cnt_nxt;
      flush_done <= last_taken;
      if (move_full) begin
        out_valid <= 1'b1;
        out_data  <= fmt_word(acc[OUT_WIDTH-1:0]);
        out_last  <= 1'b0;
        out_bytes <= BYTES_W'(OUT_WIDTH / 8);
      end else if (load_last) begin
        out_valid <= 1'b1;
        out_data  <= fmt_word(acc[OUT_WIDTH-1:0]);
        out_last  <= 1'b1;
        out_bytes <= tail_bytes;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_deflate_bit_packer.sv
// Directed self-checking bench for deflate_bit_packer (OUT_WIDTH=32, MAX_CODE_LEN=28).
// Honours PACKER_BYTE_SWAP_EN when the same define is applied to the bench.
module tb_deflate_bit_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        code_valid;
  logic [27:0] code_data;
  logic [4:0]  code_len;
  logic        code_ready;
  logic        flush;
  logic        flush_done;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic [2:0]  out_bytes;
  logic        out_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int fd_cnt   = 0;

  logic [31:0] q_data[$];
  logic [2:0]  q_bytes[$];
  logic        q_last[$];

  deflate_bit_packer dut (
    .clk(clk), .rst(rst),
    .code_valid(code_valid), .code_data(code_data), .code_len(code_len), .code_ready(code_ready),
    .flush(flush), .flush_done(flush_done),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_bytes(out_bytes),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Record every word handed downstream and every flush_done pulse
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_bytes.push_back(out_bytes);
      q_last.push_back(out_last);
    end
    if (!rst && flush_done) fd_cnt++;
  end

  function automatic logic [31:0] bswap(input logic [31:0] w);
`ifdef PACKER_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic clear_log();
    q_data.delete();
    q_bytes.delete();
    q_last.delete();
    fd_cnt = 0;
  endtask

  // Present one code and hold it until accepted (bounded)
  task automatic send(input logic [27:0] d, input logic [4:0] l);
    int tries = 0;
    bit done = 0;
    code_valid = 1'b1;
    code_data  = d;
    code_len   = l;
    while (!done && tries < 100) begin
      #1;
      done = code_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    code_valid = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL send_timeout: code %h len %0d not accepted within 100 cycles", d, l);
    end
  endtask

  task automatic do_flush();
    int tries = 0;
    bit seen = 0;
    flush = 1'b1;
    while (!seen && tries < 200) begin
      @(posedge clk);
      #1;
      seen = flush_done;
      tries++;
    end
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL flush_timeout: flush_done not seen within 200 cycles");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (code_ready !== 1'b0) begin n_fail++; $display("FAIL rst_code_ready: got %b want 0", code_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_out_last: got %b want 0", out_last); end
    n_checks++; if (out_bytes !== 3'd0) begin n_fail++; $display("FAIL rst_out_bytes: got %0d want 0", out_bytes); end
    n_checks++; if (flush_done !== 1'b0) begin n_fail++; $display("FAIL rst_flush_done: got %b want 0", flush_done); end
    rst = 1'b0;
    #1;
    n_checks++; if (code_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_code_ready: got %b want 1", code_ready); end
  endtask

  task automatic test_empty_flush();
    clear_log();
    out_ready = 1'b1;
    do_flush();
    n_checks++; if (q_data.size() != 1) begin n_fail++; $display("FAIL empty_words: got %0d want 1", q_data.size()); end
    if (q_data.size() > 0) begin
      n_checks++; if (q_data[0] !== 32'h0) begin n_fail++; $display("FAIL empty_data: got %h want 0", q_data[0]); end
      n_checks++; if (q_bytes[0] !== 3'd0) begin n_fail++; $display("FAIL empty_bytes: got %0d want 0", q_bytes[0]); end
      n_checks++; if (q_last[0] !== 1'b1) begin n_fail++; $display("FAIL empty_last: got %b want 1", q_last[0]); end
    end
    n_checks++; if (fd_cnt != 1) begin n_fail++; $display("FAIL empty_flush_done: got %0d pulses want 1", fd_cnt); end
  endtask

  // 3'b011 followed by 29 ones, split 28+1 to stay within MAX_CODE_LEN
  task automatic test_full_word();
    clear_log();
    out_ready = 1'b1;
    send(28'h3, 5'd3);
    send(28'hFFFFFFF, 5'd28);
    send(28'h1, 5'd1);
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (q_data.size() != 1) begin n_fail++; $display("FAIL full_words: got %0d want 1", q_data.size()); end
    if (q_data.size() > 0) begin
      n_checks++; if (q_data[0] !== bswap(32'hFFFFFFFB)) begin n_fail++; $display("FAIL full_data: got %h want %h", q_data[0], bswap(32'hFFFFFFFB)); end
      n_checks++; if (q_bytes[0] !== 3'd4) begin n_fail++; $display("FAIL full_bytes: got %0d want 4", q_bytes[0]); end
      n_checks++; if (q_last[0] !== 1'b0) begin n_fail++; $display("FAIL full_last: got %b want 0", q_last[0]); end
    end
    // Buffer is empty again, so flushing must yield an empty final word
    do_flush();
    n_checks++; if (q_data.size() != 2) begin n_fail++; $display("FAIL full_flush_words: got %0d want 2", q_data.size()); end
    if (q_data.size() > 1) begin
      n_checks++; if (q_bytes[1] !== 3'd0) begin n_fail++; $display("FAIL full_cnt_zero: got %0d bytes want 0", q_bytes[1]); end
    end
  endtask

  task automatic test_flush_partial();
    clear_log();
    out_ready = 1'b1;
    send(28'hABCDEF, 5'd24);
    send(28'h1234, 5'd16);
    do_flush();
    n_checks++; if (q_data.size() != 2) begin n_fail++; $display("FAIL part_words: got %0d want 2", q_data.size()); end
    if (q_data.size() > 1) begin
      n_checks++; if (q_data[0] !== bswap(32'h34ABCDEF)) begin n_fail++; $display("FAIL part_data0: got %h want %h", q_data[0], bswap(32'h34ABCDEF)); end
      n_checks++; if (q_bytes[0] !== 3'd4 || q_last[0] !== 1'b0) begin n_fail++; $display("FAIL part_meta0: got bytes %0d last %b want 4 0", q_bytes[0], q_last[0]); end
      n_checks++; if (q_data[1] !== bswap(32'h00000012)) begin n_fail++; $display("FAIL part_data1: got %h want %h", q_data[1], bswap(32'h00000012)); end
      n_checks++; if (q_bytes[1] !== 3'd1 || q_last[1] !== 1'b1) begin n_fail++; $display("FAIL part_meta1: got bytes %0d last %b want 1 1", q_bytes[1], q_last[1]); end
    end
    n_checks++; if (fd_cnt != 1) begin n_fail++; $display("FAIL part_flush_done: got %0d pulses want 1", fd_cnt); end
  endtask

  task automatic test_backpressure();
    clear_log();
    out_ready = 1'b0;
    repeat (4) send(28'hFFFF, 5'd16);
    code_valid = 1'b1;
    code_data  = 28'hFFFF;
    code_len   = 5'd16;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (code_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0", i, code_ready); end
      n_checks++; if (out_valid !== 1'b1 || out_data !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL bp_hold[%0d]: got valid %b data %h want 1 ffffffff", i, out_valid, out_data); end
      @(posedge clk);
      #1;
    end
    code_valid = 1'b0;
    out_ready  = 1'b1;
    send(28'hFFFF, 5'd16);
    do_flush();
    n_checks++; if (q_data.size() != 3) begin n_fail++; $display("FAIL bp_words: got %0d want 3", q_data.size()); end
    if (q_data.size() > 2) begin
      n_checks++; if (q_data[0] !== 32'hFFFFFFFF || q_data[1] !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL bp_full: got %h %h want ffffffff ffffffff", q_data[0], q_data[1]); end
      n_checks++; if (q_data[2] !== bswap(32'h0000FFFF)) begin n_fail++; $display("FAIL bp_tail: got %h want %h", q_data[2], bswap(32'h0000FFFF)); end
      n_checks++; if (q_bytes[2] !== 3'd2 || q_last[2] !== 1'b1) begin n_fail++; $display("FAIL bp_tail_meta: got bytes %0d last %b want 2 1", q_bytes[2], q_last[2]); end
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    out_ready = 1'b0;
    send(28'hFFFF, 5'd16);
    send(28'hFFFF, 5'd16);
    send(28'hFFFFF, 5'd20);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pending: got out_valid %b want 1", out_valid); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin n_fail++; $display("FAIL mid_rst_out: got valid %b data %h want 0 0", out_valid, out_data); end
    n_checks++; if (out_last !== 1'b0 || out_bytes !== 3'd0 || flush_done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_meta: got last %b bytes %0d fd %b want 0 0 0", out_last, out_bytes, flush_done); end
    out_ready = 1'b1;
    send(28'h5, 5'd3);
    do_flush();
    n_checks++; if (q_data.size() != 1) begin n_fail++; $display("FAIL mid_words: got %0d want 1", q_data.size()); end
    if (q_data.size() > 0) begin
      n_checks++; if (q_data[0] !== bswap(32'h00000005)) begin n_fail++; $display("FAIL mid_data: got %h want %h", q_data[0], bswap(32'h00000005)); end
      n_checks++; if (q_bytes[0] !== 3'd1 || q_last[0] !== 1'b1) begin n_fail++; $display("FAIL mid_meta: got bytes %0d last %b want 1 1", q_bytes[0], q_last[0]); end
    end
  endtask

  initial begin
    rst        = 1'b1;
    code_valid = 1'b0;
    code_data  = '0;
    code_len   = '0;
    flush      = 1'b0;
    out_ready  = 1'b1;
    test_reset();
    test_empty_flush();
    test_full_word();
    test_flush_partial();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
